nn_layer_stream: RTL and testbench

- Parametrised, streaming fully-connected layer: NUM_NEURONS parallel MAC lanes consume one shared input sample per accepted handshake, each with its own per-lane weight.
- After NUM_INPUTS samples, each lane adds bias, rescales, saturates and optionally applies ReLU, then presents all outputs as one registered vector under valid/ready.
- Successor to the fixed layer wrapper; chains layer-to-layer (out bus of layer k feeds a serialiser into layer k+1).

---
 rtl/nn_layer_stream_if.sv | 30 +++
 rtl/nn_layer_stream.sv | 118 +++++++++++
 tb/tb_nn_layer_stream.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/nn_layer_stream_if.sv
// Handshake and data bus of one streaming fully-connected layer.
// The layer sits on the slave modport; the producer/consumer side uses master.
interface nn_layer_stream_if #(
  parameter int NUM_NEURONS = 30,
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_INPUTS  = 784
);
  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  logic signed [DATA_WIDTH-1:0]               in_data;
  logic                                       in_valid;
  logic                                       in_ready;
  logic [IDX_W-1:0]                           in_index;
  logic [NUM_NEURONS*DATA_WIDTH-1:0]          weights;
  logic [NUM_NEURONS*2*DATA_WIDTH-1:0]        bias;
  logic [NUM_NEURONS*DATA_WIDTH-1:0]          out_data;
  logic                                       out_valid;
  logic                                       out_ready;
  logic                                       busy;

  modport slave (
    input  in_data, in_valid, weights, bias, out_ready,
    output in_ready, in_index, out_data, out_valid, busy
  );

  modport master (
    output in_data, in_valid, weights, bias, out_ready,
    input  in_ready, in_index, out_data, out_valid, busy
  );
endinterface

// File: rtl/nn_layer_stream.sv
// Streaming fully-connected layer: NUM_NEURONS MAC lanes share one input sample,
// then bias/rescale/saturate/ReLU and present the whole vector under valid/ready.
module nn_layer_lane #(
  parameter int DW   = 16,
  parameter int FB   = 12,
  parameter int AW   = 42,
  parameter int RELU = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 acc_en,
  input  logic                 finish,
  input  logic signed [DW-1:0] x,
  input  logic signed [DW-1:0] w,
  input  logic signed [2*DW-1:0] b,
  output logic [DW-1:0]        y
);
  localparam int SW = AW + 1;
  localparam logic signed [SW-1:0] MAXV = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [AW-1:0]   acc;
  logic signed [2*DW-1:0] prod;
  logic signed [SW-1:0]   sum, shr;
  logic [DW-1:0]          sat, act;

  assign prod = x * w;
  // One spare bit on the sum so adding the bias can never wrap.
  assign sum  = SW'(acc) + SW'(b);
  assign shr  = sum >>> FB;

  always_comb begin
    sat = shr[DW-1:0];
    if (shr > MAXV)      sat = MAXV[DW-1:0];
    else if (shr < MINV) sat = MINV[DW-1:0];
    act = sat;
    if (RELU != 0 && sat[DW-1]) act = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      y   <= '0;
    end else if (finish) begin
      acc <= '0;
      y   <= act;
    end else if (acc_en) begin
      acc <= acc + AW'(prod);
    end
  end
endmodule

module nn_layer_stream #(
  parameter int NUM_NEURONS = 30,
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 12,
  parameter int NUM_INPUTS  = 784,
  parameter int ACC_WIDTH   = 42,
  parameter int ACT_RELU    = 1
) (
  input logic                clk,
  input logic                rst,
  nn_layer_stream_if.slave   bus
);
  localparam int DW    = DATA_WIDTH;
  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  typedef enum logic [1:0] {S_ACC, S_FINISH, S_OUT} state_t;

  state_t                          state, state_nxt;
  logic [IDX_W-1:0]                idx;
  logic                            accept, last;
  logic [NUM_NEURONS-1:0][DW-1:0]  out_vec;

  assign accept = bus.in_valid && (state == S_ACC);
  assign last   = (idx == IDX_W'(NUM_INPUTS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_ACC;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_ACC:    if (accept && last) state_nxt = S_FINISH;
      S_FINISH: state_nxt = S_OUT;
      S_OUT:    if (bus.out_ready) state_nxt = S_ACC;
      default:  state_nxt = S_ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         idx <= '0;
    else if (accept) idx <= last ? '0 : idx + 1'b1;
  end

  assign bus.in_ready  = (state == S_ACC);
  assign bus.in_index  = idx;
  assign bus.out_valid = (state == S_OUT);
  assign bus.busy      = (state != S_ACC) || (idx != '0);
  assign bus.out_data  = out_vec;

  for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_lane
    nn_layer_lane #(
      .DW(DW), .FB(FRAC_BITS), .AW(ACC_WIDTH), .RELU(ACT_RELU)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .acc_en (accept),
      .finish (state == S_FINISH),
      .x      (bus.in_data),
      .w      (bus.weights[i*DW +: DW]),
      .b      (bus.bias[i*2*DW +: 2*DW]),
      .y      (out_vec[i])
    );
  end
endmodule

// File: tb/tb_nn_layer_stream.sv
// Directed bench: a linear and a ReLU layer (2 lanes, 4 inputs) fed identical streams.
module tb_nn_layer_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  nn_layer_stream_if #(.NUM_NEURONS(2), .DATA_WIDTH(16), .NUM_INPUTS(4)) lin ();
  nn_layer_stream_if #(.NUM_NEURONS(2), .DATA_WIDTH(16), .NUM_INPUTS(4)) rel ();

  assign rel.in_data   = lin.in_data;
  assign rel.in_valid  = lin.in_valid;
  assign rel.weights   = lin.weights;
  assign rel.bias      = lin.bias;
  assign rel.out_ready = lin.out_ready;

  nn_layer_stream #(.NUM_NEURONS(2), .DATA_WIDTH(16), .FRAC_BITS(12), .NUM_INPUTS(4),
                    .ACC_WIDTH(42), .ACT_RELU(0))
    dut_lin (.clk(clk), .rst(rst), .bus(lin.slave));
  nn_layer_stream #(.NUM_NEURONS(2), .DATA_WIDTH(16), .FRAC_BITS(12), .NUM_INPUTS(4),
                    .ACC_WIDTH(42), .ACT_RELU(1))
    dut_rel (.clk(clk), .rst(rst), .bus(rel.slave));

  task automatic feed(input logic [15:0] x, input int gap);
    for (int i = 0; i < 4; i++) begin
      lin.in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      lin.in_data  = x;
      lin.in_valid = 1'b1;
      @(negedge clk);
    end
    lin.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (lin.out_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic release_out();
    lin.out_ready = 1'b1;
    @(negedge clk);
    lin.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (lin.in_index !== 2'd0) $display("FAIL reset_idx got %h want 0", lin.in_index); else passed++;
    total++; if (lin.out_valid !== 1'b0) $display("FAIL reset_ovalid got %b want 0", lin.out_valid); else passed++;
    total++; if (lin.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", lin.busy); else passed++;
    total++; if (lin.out_data !== 32'h0) $display("FAIL reset_odata got %h want 0", lin.out_data); else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++; if (lin.in_ready !== 1'b1) $display("FAIL reset_iready got %b want 1", lin.in_ready); else passed++;
  endtask

  task automatic test_basic();
    lin.weights = {16'hFC00, 16'h0800};
    lin.bias    = '0;
    feed(16'h1000, 0);
    total++; if (lin.out_valid !== 1'b0) $display("FAIL basic_lat1 got %b want 0", lin.out_valid); else passed++;
    total++; if (lin.busy !== 1'b1) $display("FAIL basic_busy got %b want 1", lin.busy); else passed++;
    @(negedge clk);
    total++; if (lin.out_valid !== 1'b1) $display("FAIL basic_lat2 got %b want 1", lin.out_valid); else passed++;
    total++; if (lin.out_data !== {16'hF000, 16'h2000}) $display("FAIL basic_lin got %h want f0002000", lin.out_data); else passed++;
    total++; if (rel.out_data !== {16'h0000, 16'h2000}) $display("FAIL basic_relu got %h want 00002000", rel.out_data); else passed++;
    release_out();
    total++; if (lin.out_valid !== 1'b0 || lin.in_ready !== 1'b1)
      $display("FAIL basic_hs got valid=%b ready=%b want 0/1", lin.out_valid, lin.in_ready); else passed++;
    total++; if (lin.out_data !== {16'hF000, 16'h2000}) $display("FAIL basic_hold got %h want f0002000", lin.out_data); else passed++;
  endtask

  task automatic test_saturation();
    int n;
    lin.weights = {16'h9000, 16'h7000};
    lin.bias    = '0;
    feed(16'h7000, 0);
    wait_out(n);
    total++; if (n >= 10) $display("FAIL sat_timeout got %0d cycles want <10", n); else passed++;
    total++; if (lin.out_data !== {16'h8000, 16'h7FFF}) $display("FAIL sat_lin got %h want 80007fff", lin.out_data); else passed++;
    total++; if (rel.out_data !== {16'h0000, 16'h7FFF}) $display("FAIL sat_relu got %h want 00007fff", rel.out_data); else passed++;
    release_out();
  endtask

  task automatic test_bias();
    int n;
    lin.weights = {16'h0800, 16'h0800};
    lin.bias    = {32'hFF800000, 32'h00800000};
    feed(16'h0000, 0);
    wait_out(n);
    total++; if (n >= 10) $display("FAIL bias_timeout got %0d cycles want <10", n); else passed++;
    total++; if (lin.out_data !== {16'hF800, 16'h0800}) $display("FAIL bias_lin got %h want f8000800", lin.out_data); else passed++;
    total++; if (rel.out_data !== {16'h0000, 16'h0800}) $display("FAIL bias_relu got %h want 00000800", rel.out_data); else passed++;
    release_out();
    lin.bias = '0;
  endtask

  task automatic test_backpressure();
    int n;
    lin.weights = {16'hFC00, 16'h0800};
    feed(16'h1000, 0);
    wait_out(n);
    total++; if (n >= 10) $display("FAIL bp_timeout got %0d cycles want <10", n); else passed++;
    lin.in_data  = 16'h7000;
    lin.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++; if (lin.out_data !== {16'hF000, 16'h2000}) $display("FAIL bp_data c%0d got %h want f0002000", c, lin.out_data); else passed++;
      total++; if (lin.out_valid !== 1'b1) $display("FAIL bp_valid c%0d got %b want 1", c, lin.out_valid); else passed++;
      total++; if (lin.in_ready !== 1'b0) $display("FAIL bp_iready c%0d got %b want 0", c, lin.in_ready); else passed++;
      total++; if (lin.in_index !== 2'd0) $display("FAIL bp_idx c%0d got %h want 0", c, lin.in_index); else passed++;
    end
    lin.in_valid = 1'b0;
    release_out();
    feed(16'h1000, 0);
    wait_out(n);
    total++; if (n >= 10) $display("FAIL bp2_timeout got %0d cycles want <10", n); else passed++;
    total++; if (lin.out_data !== {16'hF000, 16'h2000}) $display("FAIL bp2_lin got %h want f0002000", lin.out_data); else passed++;
    release_out();
  endtask

  task automatic test_gapped();
    int n;
    for (int i = 0; i < 4; i++) begin
      lin.in_valid = 1'b0;
      @(negedge clk);
      total++; if (lin.in_index !== 2'(i)) $display("FAIL gap_idx%0d got %h want %0d", i, lin.in_index, i); else passed++;
      lin.in_data  = 16'h1000;
      lin.in_valid = 1'b1;
      @(negedge clk);
    end
    lin.in_valid = 1'b0;
    wait_out(n);
    total++; if (n >= 10) $display("FAIL gap_timeout got %0d cycles want <10", n); else passed++;
    total++; if (lin.out_data !== {16'hF000, 16'h2000}) $display("FAIL gap_lin got %h want f0002000", lin.out_data); else passed++;
    total++; if (rel.out_data !== {16'h0000, 16'h2000}) $display("FAIL gap_relu got %h want 00002000", rel.out_data); else passed++;
    release_out();
  endtask

  task automatic test_reset_mid();
    int n;
    lin.weights = {16'h7000, 16'h7000};
    lin.in_data = 16'h7000;
    lin.in_valid = 1'b1;
    repeat (2) @(negedge clk);
    lin.in_valid = 1'b0;
    total++; if (lin.in_index !== 2'd2) $display("FAIL mid_idx got %h want 2", lin.in_index); else passed++;
    rst = 1'b1;
    #1;
    total++; if (lin.in_index !== 2'd0) $display("FAIL mid_rst_idx got %h want 0", lin.in_index); else passed++;
    total++; if (lin.out_valid !== 1'b0) $display("FAIL mid_rst_valid got %b want 0", lin.out_valid); else passed++;
    total++; if (lin.busy !== 1'b0) $display("FAIL mid_rst_busy got %b want 0", lin.busy); else passed++;
    @(negedge clk);
    rst = 1'b0;
    lin.weights = {16'hFC00, 16'h0800};
    feed(16'h1000, 0);
    wait_out(n);
    total++; if (n >= 10) $display("FAIL mid_timeout got %0d cycles want <10", n); else passed++;
    total++; if (lin.out_data !== {16'hF000, 16'h2000}) $display("FAIL mid_lin got %h want f0002000", lin.out_data); else passed++;
    release_out();
  endtask

  initial begin
    lin.in_data   = '0;
    lin.in_valid  = 1'b0;
    lin.weights   = '0;
    lin.bias      = '0;
    lin.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_saturation();
    test_bias();
    test_backpressure();
    test_gapped();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
